// File: rtl/spi_sd_responder_if.sv
// Host-side handshake bundle for the SPI SD responder: TX buffer write port,
// RX byte read port and status flags.
interface spi_sd_responder_if;
   logic [7:0] TxData;
   logic       TxValid;
   logic       TxReady;
   logic [7:0] RxData;
   logic       RxValid;
   logic       RxAck;
   logic       Overrun;
   logic       Busy;

   modport slave (
      input  TxData, TxValid, RxAck,
      output TxReady, RxData, RxValid, Overrun, Busy
   );

   modport master (
      output TxData, TxValid, RxAck,
      input  TxReady, RxData, RxValid, Overrun, Busy
   );
endinterface

// File: rtl/spi_sd_responder.sv
// SPI mode-0 target oversampled on MasterCLK: one-entry TX buffer, single RX
// holding register with sticky overrun.
module spi_sd_responder #(
   parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
   input  logic                MasterCLK,
   input  logic                Reset,
   input  logic                SPI_CLK,
   input  logic                SPI_CS,
   input  logic                SPI_MOSI,
   output logic                SPI_MISO,
   spi_sd_responder_if.slave   host
);

   typedef enum logic [1:0] {WAITHIGH, IDLE, SHIFT} state_e;

   state_e     state_q, state_d;
   logic [1:0] sclk_sync_q, sclk_sync_d;
   logic [1:0] cs_sync_q, cs_sync_d;
   logic [1:0] mosi_sync_q, mosi_sync_d;
   logic       sclk_prev_q, sclk_prev_d;
   logic       cs_prev_q, cs_prev_d;
   logic [1:0] fill_q, fill_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] rx_sr_q, rx_sr_d;
   logic [7:0] tx_sr_q, tx_sr_d;
   logic [7:0] buf_q, buf_d;
   logic       buf_vld_q, buf_vld_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       overrun_q, overrun_d;
   logic       miso_q, miso_d;
   logic       busy_q, busy_d;

   logic       sclk_s, cs_s, mosi_s;
   logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic       reload, rx_done, tx_write;
   logic [7:0] rx_byte;

   assign sclk_s    = sclk_sync_q[1];
   assign cs_s      = cs_sync_q[1];
   assign mosi_s    = mosi_sync_q[1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign cs_rise   = cs_s & ~cs_prev_q;
   assign cs_fall   = ~cs_s & cs_prev_q;
   assign rx_byte   = {rx_sr_q[6:0], mosi_s};
   assign tx_write  = host.TxValid & ~buf_vld_q;

   always_comb begin
      state_d     = state_q;
      sclk_sync_d = {sclk_sync_q[0], SPI_CLK};
      cs_sync_d   = {cs_sync_q[0], SPI_CS};
      mosi_sync_d = {mosi_sync_q[0], SPI_MOSI};
      sclk_prev_d = sclk_s;
      cs_prev_d   = cs_s;
      fill_d      = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
      cnt_d       = cnt_q;
      rx_sr_d     = rx_sr_q;
      tx_sr_d     = tx_sr_q;
      buf_d       = buf_q;
      buf_vld_d   = buf_vld_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      overrun_d   = overrun_q;
      reload      = 1'b0;
      rx_done     = 1'b0;

      case (state_q)
         // The synchronizer holds its reset value for two cycles; only trust
         // CS high once real pin samples have reached the output stage.
         WAITHIGH: if (fill_q == 2'd2 && cs_s) state_d = IDLE;
         IDLE: if (cs_fall) begin
            state_d = SHIFT;
            cnt_d   = 4'd0;
            reload  = 1'b1;
         end
         SHIFT: begin
            if (cs_rise) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else if (sclk_rise) begin
               rx_sr_d = rx_byte;
               cnt_d   = cnt_q + 4'd1;
               rx_done = (cnt_q == 4'd7);
            end else if (sclk_fall) begin
               if (cnt_q == 4'd8) begin
                  reload = 1'b1;
                  cnt_d  = 4'd0;
               end else begin
                  tx_sr_d = tx_sr_q << 1;
               end
            end
         end
         default: state_d = WAITHIGH;
      endcase

      if (reload) begin
         tx_sr_d   = buf_vld_q ? buf_q : IDLE_BYTE;
         buf_vld_d = 1'b0;
      end
      // A write can only land on an empty buffer, so it never races a reload
      // that is draining a full one.
      if (tx_write) begin
         buf_d     = host.TxData;
         buf_vld_d = 1'b1;
      end

      if (rx_done) begin
         if (!rx_valid_q || host.RxAck) begin
            rx_data_d  = rx_byte;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (host.RxAck) begin
         rx_valid_d = 1'b0;
      end

      busy_d = (state_d == SHIFT);
      miso_d = busy_d ? tx_sr_d[7] : 1'b1;
   end

   always_ff @(posedge MasterCLK) begin
      if (!Reset) begin
         state_q     <= WAITHIGH;
         sclk_sync_q <= 2'b00;
         cs_sync_q   <= 2'b11;
         mosi_sync_q <= 2'b11;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b1;
         fill_q      <= 2'd0;
         cnt_q       <= 4'd0;
         rx_sr_q     <= 8'h00;
         tx_sr_q     <= IDLE_BYTE;
         buf_q       <= 8'h00;
         buf_vld_q   <= 1'b0;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         overrun_q   <= 1'b0;
         miso_q      <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sclk_sync_q <= sclk_sync_d;
         cs_sync_q   <= cs_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sclk_prev_q <= sclk_prev_d;
         cs_prev_q   <= cs_prev_d;
         fill_q      <= fill_d;
         cnt_q       <= cnt_d;
         rx_sr_q     <= rx_sr_d;
         tx_sr_q     <= tx_sr_d;
         buf_q       <= buf_d;
         buf_vld_q   <= buf_vld_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         overrun_q   <= overrun_d;
         miso_q      <= miso_d;
         busy_q      <= busy_d;
      end
   end

   assign SPI_MISO     = miso_q;
   assign host.TxReady = ~buf_vld_q;
   assign host.RxData  = rx_data_q;
   assign host.RxValid = rx_valid_q;
   assign host.Overrun = overrun_q;
   assign host.Busy    = busy_q;

endmodule

// File: tb/tb_spi_sd_responder.sv
// Randomized bench for spi_sd_responder against a byte-level model of the
// TX buffer and RX holding register.
module tb_spi_sd_responder;
   localparam logic [7:0] IDLE = 8'hFF;

   logic MasterCLK = 1'b0;
   logic Reset, SPI_CLK, SPI_CS, SPI_MOSI, SPI_MISO;
   spi_sd_responder_if hif();

   spi_sd_responder #(.IDLE_BYTE(IDLE)) dut (
      .MasterCLK (MasterCLK),
      .Reset     (Reset),
      .SPI_CLK   (SPI_CLK),
      .SPI_CS    (SPI_CS),
      .SPI_MOSI  (SPI_MOSI),
      .SPI_MISO  (SPI_MISO),
      .host      (hif)
   );

   always #5 MasterCLK = ~MasterCLK;

   int n_chk = 0, n_pass = 0;

   logic [7:0] mosi_b[4], miso_b[4], rxd_o[4], exp_rxd[4];
   logic [7:0] exp_miso[5];
   logic       rxv_o[4], exp_rxv[4], ovr_o[4], exp_ovr[4];
   logic       txr_fall, busy_fall;

   // byte-level model state
   logic       m_buf_vld, m_rxv, m_ovr;
   logic [7:0] m_buf, m_rxd;

   task automatic m_init();
      m_buf_vld = 0; m_buf = 0; m_rxv = 0; m_rxd = 0; m_ovr = 0;
   endtask

   task automatic m_reload(output logic [7:0] b);
      if (m_buf_vld) begin b = m_buf; m_buf_vld = 0; end
      else b = IDLE;
   endtask

   task automatic tx_write(input logic [7:0] v);
      hif.TxValid = 1; hif.TxData = v;
      @(negedge MasterCLK);
      hif.TxValid = 0;
      if (!m_buf_vld) begin m_buf = v; m_buf_vld = 1; end
   endtask

   task automatic ack_rx();
      hif.RxAck = 1;
      @(negedge MasterCLK);
      hif.RxAck = 0;
      m_rxv = 0;
   endtask

   // One CS-low frame of nbits SPI clocks (10 MasterCLK per SPI clock).
   // Optionally acks each completed byte and writes race_val exactly in the
   // cycle the responder reloads after byte race_byte.
   task automatic run_frame(input int nbits, input bit ack, input int race_byte,
                            input logic [7:0] race_val);
      int b, i;
      logic empty;
      SPI_CS = 0;
      m_reload(exp_miso[0]);
      repeat (5) @(negedge MasterCLK);
      txr_fall = hif.TxReady; busy_fall = hif.Busy;
      for (int t = 0; t < nbits; t++) begin
         b = t / 8; i = 7 - (t % 8);
         SPI_MOSI = mosi_b[b][i];
         @(negedge MasterCLK);
         SPI_CLK = 1;
         miso_b[b][i] = SPI_MISO;
         repeat (4) @(negedge MasterCLK);
         if (i == 0) begin
            if (m_rxv) m_ovr = 1;
            else begin m_rxv = 1; m_rxd = mosi_b[b]; end
            rxv_o[b] = hif.RxValid; rxd_o[b] = hif.RxData; ovr_o[b] = hif.Overrun;
            exp_rxv[b] = m_rxv; exp_rxd[b] = m_rxd; exp_ovr[b] = m_ovr;
            if (ack) begin hif.RxAck = 1; m_rxv = 0; end
         end
         @(negedge MasterCLK);
         hif.RxAck = 0;
         SPI_CLK = 0;
         if (i == 0) begin
            empty = !m_buf_vld;
            m_reload(exp_miso[b+1]);
            if (b == race_byte) begin
               repeat (2) @(negedge MasterCLK);
               hif.TxValid = 1; hif.TxData = race_val;
               @(negedge MasterCLK);
               hif.TxValid = 0;
               if (empty) begin m_buf = race_val; m_buf_vld = 1; end
               @(negedge MasterCLK);
            end else repeat (4) @(negedge MasterCLK);
         end else repeat (4) @(negedge MasterCLK);
      end
      repeat (3) @(negedge MasterCLK);
      SPI_CS = 1;
      repeat (6) @(negedge MasterCLK);
   endtask

   task automatic test_reset();
      Reset = 0;
      repeat (3) @(negedge MasterCLK);
      n_chk++; if (hif.RxValid !== 1'b0) $display("FAIL reset_rxvalid got %b want 0", hif.RxValid); else n_pass++;
      n_chk++; if (hif.RxData !== 8'h00) $display("FAIL reset_rxdata got %h want 00", hif.RxData); else n_pass++;
      n_chk++; if (hif.Overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", hif.Overrun); else n_pass++;
      n_chk++; if (hif.TxReady !== 1'b1) $display("FAIL reset_txready got %b want 1", hif.TxReady); else n_pass++;
      n_chk++; if (hif.Busy !== 1'b0) $display("FAIL reset_busy got %b want 0", hif.Busy); else n_pass++;
      n_chk++; if (SPI_MISO !== 1'b1) $display("FAIL reset_miso got %b want 1", SPI_MISO); else n_pass++;
      Reset = 1;
      m_init();
      repeat (5) @(negedge MasterCLK);
   endtask

   task automatic test_basic();
      tx_write(8'hA5);
      n_chk++; if (hif.TxReady !== 1'b0) $display("FAIL basic_txready_full got %b want 0", hif.TxReady); else n_pass++;
      mosi_b[0] = 8'h3C;
      run_frame(8, 0, -1, 8'h00);
      n_chk++; if (txr_fall !== 1'b1) $display("FAIL basic_txready_csfall got %b want 1", txr_fall); else n_pass++;
      n_chk++; if (busy_fall !== 1'b1) $display("FAIL basic_busy_inframe got %b want 1", busy_fall); else n_pass++;
      n_chk++; if (miso_b[0] !== 8'hA5) $display("FAIL basic_miso got %h want a5", miso_b[0]); else n_pass++;
      n_chk++; if (hif.RxData !== 8'h3C) $display("FAIL basic_rxdata got %h want 3c", hif.RxData); else n_pass++;
      n_chk++; if (hif.RxValid !== 1'b1) $display("FAIL basic_rxvalid got %b want 1", hif.RxValid); else n_pass++;
      n_chk++; if (hif.Busy !== 1'b0) $display("FAIL basic_busy_after got %b want 0", hif.Busy); else n_pass++;
      ack_rx();
      n_chk++; if (hif.RxValid !== 1'b0) $display("FAIL basic_ack got %b want 0", hif.RxValid); else n_pass++;
   endtask

   task automatic test_idle_two();
      for (int k = 0; k < 2; k++) mosi_b[k] = 8'($urandom);
      run_frame(16, 1, -1, 8'h00);
      for (int k = 0; k < 2; k++) begin
         n_chk++; if (miso_b[k] !== exp_miso[k]) $display("FAIL idle_miso[%0d] got %h want %h", k, miso_b[k], exp_miso[k]); else n_pass++;
         n_chk++; if (rxv_o[k] !== exp_rxv[k]) $display("FAIL idle_rxvalid[%0d] got %b want %b", k, rxv_o[k], exp_rxv[k]); else n_pass++;
         n_chk++; if (rxd_o[k] !== exp_rxd[k]) $display("FAIL idle_rxdata[%0d] got %h want %h", k, rxd_o[k], exp_rxd[k]); else n_pass++;
      end
   endtask

   task automatic test_overrun();
      for (int k = 0; k < 2; k++) mosi_b[k] = 8'($urandom);
      run_frame(16, 0, -1, 8'h00);
      n_chk++; if (hif.RxData !== m_rxd) $display("FAIL ovr_rxdata got %h want %h", hif.RxData, m_rxd); else n_pass++;
      n_chk++; if (hif.Overrun !== m_ovr) $display("FAIL ovr_flag got %b want %b", hif.Overrun, m_ovr); else n_pass++;
      n_chk++; if (hif.RxValid !== m_rxv) $display("FAIL ovr_rxvalid got %b want %b", hif.RxValid, m_rxv); else n_pass++;
      ack_rx();
      mosi_b[0] = 8'($urandom);
      run_frame(8, 1, -1, 8'h00);
      n_chk++; if (ovr_o[0] !== exp_ovr[0]) $display("FAIL ovr_sticky got %b want %b", ovr_o[0], exp_ovr[0]); else n_pass++;
      n_chk++; if (rxd_o[0] !== exp_rxd[0]) $display("FAIL ovr_next_rxdata got %h want %h", rxd_o[0], exp_rxd[0]); else n_pass++;
   endtask

   task automatic test_abort();
      mosi_b[0] = 8'($urandom);
      run_frame(5, 0, -1, 8'h00);
      n_chk++; if (hif.RxValid !== m_rxv) $display("FAIL abort_rxvalid got %b want %b", hif.RxValid, m_rxv); else n_pass++;
      n_chk++; if (hif.Busy !== 1'b0) $display("FAIL abort_busy got %b want 0", hif.Busy); else n_pass++;
      tx_write(8'($urandom));
      mosi_b[0] = 8'($urandom);
      run_frame(8, 1, -1, 8'h00);
      n_chk++; if (miso_b[0] !== exp_miso[0]) $display("FAIL abort_next_miso got %h want %h", miso_b[0], exp_miso[0]); else n_pass++;
      n_chk++; if (rxd_o[0] !== exp_rxd[0]) $display("FAIL abort_next_rxdata got %h want %h", rxd_o[0], exp_rxd[0]); else n_pass++;
      n_chk++; if (rxv_o[0] !== exp_rxv[0]) $display("FAIL abort_next_rxvalid got %b want %b", rxv_o[0], exp_rxv[0]); else n_pass++;
   endtask

   task automatic test_reset_midframe();
      logic [7:0] miso_seen;
      logic busy_seen;
      SPI_CS = 0;
      repeat (5) @(negedge MasterCLK);
      for (int k = 0; k < 3; k++) begin
         SPI_MOSI = 1'($urandom); @(negedge MasterCLK);
         SPI_CLK = 1; repeat (5) @(negedge MasterCLK);
         SPI_CLK = 0; repeat (4) @(negedge MasterCLK);
      end
      Reset = 0;
      repeat (2) @(negedge MasterCLK);
      Reset = 1;
      m_init();
      busy_seen = 0; miso_seen = 8'h00;
      for (int k = 0; k < 8; k++) begin
         SPI_MOSI = 1'($urandom); @(negedge MasterCLK);
         SPI_CLK = 1;
         miso_seen[7-k] = SPI_MISO;
         busy_seen = busy_seen | hif.Busy;
         repeat (5) @(negedge MasterCLK);
         SPI_CLK = 0; repeat (4) @(negedge MasterCLK);
      end
      n_chk++; if (busy_seen !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy_seen); else n_pass++;
      n_chk++; if (miso_seen !== 8'hFF) $display("FAIL rstmid_miso got %h want ff", miso_seen); else n_pass++;
      n_chk++; if (hif.RxValid !== m_rxv) $display("FAIL rstmid_rxvalid got %b want %b", hif.RxValid, m_rxv); else n_pass++;
      n_chk++; if (hif.Overrun !== m_ovr) $display("FAIL rstmid_overrun got %b want %b", hif.Overrun, m_ovr); else n_pass++;
      SPI_CS = 1;
      repeat (6) @(negedge MasterCLK);
      tx_write(8'($urandom));
      mosi_b[0] = 8'($urandom);
      run_frame(8, 1, -1, 8'h00);
      n_chk++; if (miso_b[0] !== exp_miso[0]) $display("FAIL rstmid_next_miso got %h want %h", miso_b[0], exp_miso[0]); else n_pass++;
      n_chk++; if (rxd_o[0] !== exp_rxd[0]) $display("FAIL rstmid_next_rxdata got %h want %h", rxd_o[0], exp_rxd[0]); else n_pass++;
      n_chk++; if (rxv_o[0] !== exp_rxv[0]) $display("FAIL rstmid_next_rxvalid got %b want %b", rxv_o[0], exp_rxv[0]); else n_pass++;
   endtask

   task automatic test_reload_race();
      logic [7:0] first, late;
      first = 8'($urandom_range(0, 254));
      late  = 8'($urandom_range(0, 254));
      tx_write(first);
      for (int k = 0; k < 3; k++) mosi_b[k] = 8'($urandom);
      run_frame(24, 1, 0, late);
      n_chk++; if (miso_b[0] !== first) $display("FAIL race_byte0 got %h want %h", miso_b[0], first); else n_pass++;
      n_chk++; if (miso_b[1] !== IDLE) $display("FAIL race_byte1_idle got %h want %h", miso_b[1], IDLE); else n_pass++;
      n_chk++; if (miso_b[2] !== late) $display("FAIL race_byte2_written got %h want %h", miso_b[2], late); else n_pass++;
      for (int k = 0; k < 3; k++) begin
         n_chk++; if (miso_b[k] !== exp_miso[k]) $display("FAIL race_model_miso[%0d] got %h want %h", k, miso_b[k], exp_miso[k]); else n_pass++;
         n_chk++; if (rxd_o[k] !== exp_rxd[k]) $display("FAIL race_rxdata[%0d] got %h want %h", k, rxd_o[k], exp_rxd[k]); else n_pass++;
      end
      n_chk++; if (hif.TxReady !== !m_buf_vld) $display("FAIL race_txready_end got %b want %b", hif.TxReady, !m_buf_vld); else n_pass++;
   endtask

   initial begin
      Reset = 0; SPI_CLK = 0; SPI_CS = 1; SPI_MOSI = 1;
      hif.TxData = 8'h00; hif.TxValid = 0; hif.RxAck = 0;
      m_init();
      @(negedge MasterCLK);
      test_reset();
      test_basic();
      test_idle_two();
      test_overrun();
      test_abort();
      test_reset_midframe();
      test_reload_race();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
      $fatal(1);
   end
endmodule
